ysyx_22041412_mdu: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RV64M operation set, including the W-suffix word forms. It sits beside the combinational ALU in the execute stage. It takes operands through a valid/ready handshake, computes over multiple cycles, and returns the result through a second valid/ready handshake, so the pipeline can stall or flush around it. Hardware cost is one shift-add multiplier datapath and one restoring divider datapath, sharing a single accumulator and counter.

---
 rtl/ysyx_22041412_mdu.sv | 173 +++++++++++++++++
 tb/tb_ysyx_22041412_mdu.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_mdu.sv
// RV64M iterative multiply/divide unit.
// One shift-add multiplier step and one restoring divider step share a
// 2*XLEN accumulator and an iteration counter. Requests and results each
// use a valid/ready handshake; flush aborts whatever is in flight.
module ysyx_22041412_mdu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      func3,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int WLEN = XLEN / 2;
    localparam int CW   = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, nxt;

    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opa;     // multiplicand or divisor magnitude
    logic [2:0]        op_f3;
    logic              op_w;
    logic              neg_q;   // negate product / quotient
    logic              neg_r;   // negate remainder
    logic [XLEN-1:0]   res;

    function automatic logic [XLEN-1:0] wsext(input logic [XLEN-1:0] v);
        return {{WLEN{v[WLEN-1]}}, v[WLEN-1:0]};
    endfunction

    function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v, input logic sgn);
        return sgn ? wsext(v) : {{WLEN{1'b0}}, v[WLEN-1:0]};
    endfunction

    // ---------------- request decode ----------------
    logic            accept, in_div, a_sgn, b_sgn, a_neg, b_neg;
    logic            div0, ovf, fast;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, fast_res;

    assign accept  = in_valid && in_ready && !flush;
    assign in_div  = func3[2];
    // MULHSU keeps src1 signed; MULHU and the unsigned divides use raw bits.
    assign a_sgn   = in_div ? ~func3[0] : (func3 != 3'b011);
    assign b_sgn   = in_div ? ~func3[0] : ~func3[1];
    assign a_ext   = is_word ? wext(src1, a_sgn) : src1;
    assign b_ext   = is_word ? wext(src2, b_sgn) : src2;
    assign a_neg   = a_sgn & a_ext[XLEN-1];
    assign b_neg   = b_sgn & b_ext[XLEN-1];
    assign a_mag   = a_neg ? -a_ext : a_ext;
    assign b_mag   = b_neg ? -b_ext : b_ext;
    assign min_val = is_word ? {{(WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                             : {1'b1, {(XLEN-1){1'b0}}};
    assign div0    = in_div && (b_ext == '0);
    assign ovf     = in_div && a_sgn && (a_ext == min_val) && (b_ext == '1);
    assign fast    = div0 || ovf;

    // Results for the cases that skip iteration entirely
    always_comb begin
        fast_res = '0;
        if (div0)
            fast_res = func3[1] ? (is_word ? wsext(src1) : src1) : '1;
        else
            fast_res = func3[1] ? '0 : a_ext;
    end

    // ---------------- one iteration ----------------
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic              div_ge, last;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt;

    // Multiply: {hi,lo} shifts right, hi accumulates the multiplicand when lo[0].
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);
    assign mul_nxt  = {mul_sum, acc[XLEN-1:1]};
    // Divide: {rem,dividend} shifts left, quotient bits enter at bit 0.
    assign div_sh   = acc[2*XLEN-1:XLEN-1];
    assign div_diff = div_sh - {1'b0, opa};
    assign div_ge   = ~div_diff[XLEN];
    assign div_nxt  = {div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0], acc[XLEN-2:0], div_ge};
    assign acc_nxt  = op_f3[2] ? div_nxt : mul_nxt;
    assign last     = (cnt == (op_w ? CW'(WLEN-1) : CW'(XLEN-1)));

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo, rmd, val, calc_res;

    // Sign-correct the finished accumulator and pick the requested half
    always_comb begin
        // After WLEN right shifts the word product sits WLEN bits up.
        prod   = op_w ? (acc_nxt >> WLEN) : acc_nxt;
        prod_s = neg_q ? -prod : prod;
        quo    = acc_nxt[XLEN-1:0];
        rmd    = acc_nxt[2*XLEN-1:XLEN];
        if (neg_q) quo = -quo;
        if (neg_r) rmd = -rmd;
        if (op_f3[2])
            val = op_f3[1] ? rmd : quo;
        else if (op_f3[1:0] == 2'b00 || op_w)
            val = prod_s[XLEN-1:0];
        else
            val = prod_s[2*XLEN-1:XLEN];
        calc_res = op_w ? wsext(val) : val;
    end

    // ---------------- FSM ----------------
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = fast ? DONE : CALC;
            CALC:    if (last) nxt = DONE;
            DONE:    if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (flush) nxt = IDLE;
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        result    = res;
    end

    // Datapath: latch operands on accept, iterate in CALC, capture on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            acc   <= '0;
            opa   <= '0;
            op_f3 <= '0;
            op_w  <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            res   <= '0;
        end else if (accept) begin
            op_f3 <= func3;
            op_w  <= is_word;
            cnt   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (in_div) begin
                // Word dividend is pre-shifted so WLEN steps drain it into the remainder.
                acc <= {{XLEN{1'b0}}, is_word ? {a_mag[WLEN-1:0], {WLEN{1'b0}}} : a_mag};
                opa <= b_mag;
            end else begin
                acc <= {{XLEN{1'b0}}, b_mag};
                opa <= a_mag;
            end
            if (fast) res <= fast_res;
        end else if (state == CALC && !flush) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
            if (last) res <= calc_res;
        end
    end
endmodule

// File: tb/tb_ysyx_22041412_mdu.sv
// Bench for the RV64M multiply/divide unit: directed scenarios plus a
// randomized sweep against an arithmetic reference model.
module tb_ysyx_22041412_mdu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  func3 = '0;
    logic        is_word = 1'b0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ysyx_22041412_mdu #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .func3(func3), .is_word(is_word), .src1(src1), .src2(src2),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: plain SV arithmetic on the RISC-V definitions
    function automatic logic [63:0] ref_mdu(input logic [2:0] f, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] ps;
        logic [127:0]        pu;
        longint              sa, sb;
        int                  wa, wb;
        logic [31:0]         r32;
        logic [63:0]         r;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0];
        r = '0; r32 = '0;
        if (w) begin
            case (f)
                3'd4: if (wb == 0) r32 = '1;
                      else if (wa == int'(32'h8000_0000) && wb == -1) r32 = wa;
                      else r32 = wa / wb;
                3'd5: r32 = (b[31:0] == 0) ? '1 : a[31:0] / b[31:0];
                3'd6: if (wb == 0) r32 = wa;
                      else if (wa == int'(32'h8000_0000) && wb == -1) r32 = '0;
                      else r32 = wa % wb;
                3'd7: r32 = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0];
                default: r32 = wa * wb;
            endcase
            return {{32{r32[31]}}, r32};
        end
        case (f)
            3'd0: r = a * b;
            3'd1: begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = ps[127:64]; end
            3'd2: begin ps = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); r = ps[127:64]; end
            3'd3: begin pu = {64'b0, a} * {64'b0, b}; r = pu[127:64]; end
            3'd4: if (sb == 0) r = '1;
                  else if (a == 64'h8000_0000_0000_0000 && sb == -1) r = a;
                  else r = sa / sb;
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: if (sb == 0) r = a;
                  else if (a == 64'h8000_0000_0000_0000 && sb == -1) r = '0;
                  else r = sa % sb;
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Edges from accept to out_valid: 0 for divide-by-zero / overflow, else N
    function automatic int exp_lat(input logic [2:0] f, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        if (!f[2]) return w ? 32 : 64;
        if (w ? (b[31:0] == 0) : (b == 0)) return 0;
        if (!f[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == '1))) return 0;
        return w ? 32 : 64;
    endfunction

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 9))
            0: return 64'd0;
            1: return 64'd1;
            2: return '1;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'hFFFF_FFFF_8000_0000;
            5: return 64'h0000_0000_FFFF_FFFF;
            6: return {32'h0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Issue one op, wait (bounded) for out_valid, consume it if out_ready
    task automatic run_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] r, output int lat);
        @(negedge clk);
        func3 = f; is_word = w; src1 = a; src2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        if (out_valid && out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b res=%h, want 1 0 0 0",
                     in_ready, out_valid, busy, result);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  f  [13] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd5, 3'd4, 3'd0, 3'd2};
        logic        w  [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [63:0] a  [13] = '{64'd7, '1, '1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                                 64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9,
                                 64'h8000_0000, 64'h1234_5678_0000_0009, 64'h0000_0001_8000_0000, 64'd6};
        logic [63:0] b  [13] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd2, '1, '1, '1, 64'd0, 64'd0,
                                 64'd2, 64'd2, 64'd1, 64'hFFFF_FFFF_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] ex [13] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'd1, 64'd0, 64'h8000_0000_0000_0000, 64'd0,
                                 '1, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, '1,
                                 64'hFFFF_FFFF_8000_0000, '1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFA};
        int          el [13] = '{64, 64, 64, 0, 0, 0, 0, 32, 32, 32, 0, 32, 32};
        logic [63:0] r;
        int          lat;
        for (int i = 0; i < 13; i++) begin
            run_op(f[i], w[i], a[i], b[i], r, lat);
            checks++;
            if (r !== ex[i]) begin
                errors++;
                $display("FAIL directed[%0d] result: got %h want %h", i, r, ex[i]);
            end
            checks++;
            if (lat != el[i]) begin
                errors++;
                $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, el[i]);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [63:0] r0, r;
        int          lat;
        logic        stable;
        out_ready = 1'b0;
        run_op(3'd5, 1'b0, 64'd100, 64'd7, r0, lat);
        checks++;
        if (r0 !== 64'd14 || lat != 64) begin
            errors++;
            $display("FAIL bp first: got %h lat %0d want 14 lat 64", r0, lat);
        end
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (result !== r0 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp hold: result/out_valid/in_ready changed while stalled (res %h)", result);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp release: rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
        run_op(3'd7, 1'b0, 64'd100, 64'd7, r, lat);
        checks++;
        if (r !== 64'd2 || lat != 64) begin
            errors++;
            $display("FAIL bp second: got %h lat %0d want 2 lat 64", r, lat);
        end
    endtask

    task automatic test_flush();
        logic [63:0] r;
        int          lat;
        logic        seen;
        @(negedge clk);
        func3 = 3'd4; is_word = 1'b0; src1 = 64'd1000; src2 = 64'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush idle: rdy=%b busy=%b want 1 0", in_ready, busy);
        end
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush drop: out_valid rose=%b want 0", seen);
        end
        run_op(3'd0, 1'b0, 64'd3, 64'd4, r, lat);
        checks++;
        if (r !== 64'd12 || lat != 64) begin
            errors++;
            $display("FAIL flush next mul: got %h lat %0d want 12 lat 64", r, lat);
        end
        @(negedge clk);
        func3 = 3'd0; src1 = 64'd3; src2 = 64'd4; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush block accept: busy=%b rdy=%b want 0 1", busy, in_ready);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        func3 = 3'd0; is_word = 1'b0; src1 = 64'd9; src2 = 64'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async reset: rdy=%b vld=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic        w;
        logic [63:0] a, b, r, ex;
        int          lat, el;
        for (int i = 0; i < 1000; i++) begin
            f = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            a = rnd_val();
            b = rnd_val();
            ex = ref_mdu(f, w, a, b);
            el = exp_lat(f, w, a, b);
            run_op(f, w, a, b, r, lat);
            checks++;
            if (r !== ex) begin
                errors++;
                $display("FAIL random[%0d] f3=%0d w=%b a=%h b=%h: got %h want %h", i, f, w, a, b, r, ex);
            end
            checks++;
            if (lat != el) begin
                errors++;
                $display("FAIL random[%0d] latency f3=%0d w=%b: got %0d want %0d", i, f, w, lat, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
